// File: rtl/config_frame_pkg.sv
// Shared types and header field layout for the configuration frame writer.
package config_frame_pkg;

   // Frame writer sequencing states.
   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      LOAD    = 3'd1,
      DISCARD = 3'd2,
      STROBE  = 3'd3,
      HOLD    = 3'd4
   } state_e;

   // Header word layout: column in the low byte, frame index in the next byte.
   localparam int COL_LSB = 0;
   localparam int FRM_LSB = 8;
   localparam int FIELD_W = 8;

endpackage

// File: rtl/frame_strobe_decoder.sv
// Registered (column, frame, enable) -> one-hot FrameStrobe decoder.
// The output bit col*MaxFramesPerCol+frame is high in the cycle after en_i.
module frame_strobe_decoder
   import config_frame_pkg::*;
#(
   parameter int NumColumns      = 10,
   parameter int MaxFramesPerCol = 20
) (
   input  logic                                  clk_i,
   input  logic                                  rst_ni,
   input  logic                                  en_i,
   input  logic [FIELD_W-1:0]                    col_i,
   input  logic [FIELD_W-1:0]                    frame_i,
   output logic [NumColumns*MaxFramesPerCol-1:0] strobe_o
);

   localparam int NumStrobes = NumColumns * MaxFramesPerCol;

   logic [NumStrobes-1:0] strobe_d;
   logic [NumStrobes-1:0] strobe_q;
   int                    strobe_idx;

   // Decode the flat strobe index; at most one bit can match.
   always_comb begin
      strobe_d   = '0;
      strobe_idx = int'(col_i) * MaxFramesPerCol + int'(frame_i);
      for (int i = 0; i < NumStrobes; i++) begin
         strobe_d[i] = en_i && (strobe_idx == i);
      end
   end

   // Register the strobe so it never glitches from upstream logic.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         strobe_q <= '0;
      end else begin
         strobe_q <= strobe_d;
      end
   end

   assign strobe_o = strobe_q;

endmodule

// File: rtl/config_frame_writer.sv
// Configuration frame writer: collects a header plus NumRows data words,
// drives them on FrameData, then pulses one FrameStrobe bit for the column.
//
// Input stream handshake: a word transfers on a CLK rise where s_valid and
// s_ready are both high. s_ready depends only on the current state; s_valid
// may be held low for any number of cycles between words.
module config_frame_writer
   import config_frame_pkg::*;
#(
   parameter int MaxFramesPerCol = 20,
   parameter int FrameBitsPerRow = 32,
   parameter int NumRows         = 8,
   parameter int NumColumns      = 10,
   parameter int StrobeCycles    = 1
) (
   input  logic                                  CLK,
   input  logic                                  resetn,
   input  logic                                  s_valid,
   output logic                                  s_ready,
   input  logic [FrameBitsPerRow-1:0]            s_data,
   output logic [NumRows*FrameBitsPerRow-1:0]    FrameData,
   output logic [NumColumns*MaxFramesPerCol-1:0] FrameStrobe,
   output logic                                  frame_done,
   output logic                                  frame_err,
   output logic                                  busy,
   output state_e                                dbg_state
);

   localparam int              RowW     = $clog2(NumRows + 1);
   localparam logic [RowW-1:0] LAST_ROW = RowW'(NumRows - 1);
   localparam logic [3:0]      LAST_STB = 4'(StrobeCycles - 1);

   state_e                             state_q, state_d;
   logic [RowW-1:0]                    row_q, row_d;
   logic [3:0]                         cnt_q, cnt_d;
   logic [FIELD_W-1:0]                 col_q, col_d;
   logic [FIELD_W-1:0]                 frm_q, frm_d;
   logic                               err_q, err_d;
   logic [NumRows*FrameBitsPerRow-1:0] frame_data_q;
   logic                               wr_en;
   logic                               hdr_ok;
   logic [FIELD_W-1:0]                 hdr_col;
   logic [FIELD_W-1:0]                 hdr_frm;

   assign hdr_col = s_data[COL_LSB +: FIELD_W];
   assign hdr_frm = s_data[FRM_LSB +: FIELD_W];
   assign hdr_ok  = ({1'b0, hdr_col} < 9'(NumColumns)) &&
                    ({1'b0, hdr_frm} < 9'(MaxFramesPerCol));

   // Next-state logic, row/strobe counting and the ready/write strobes.
   always_comb begin
      state_d = state_q;
      row_d   = row_q;
      cnt_d   = cnt_q;
      col_d   = col_q;
      frm_d   = frm_q;
      err_d   = 1'b0;
      s_ready = 1'b0;
      wr_en   = 1'b0;
      case (state_q)
         IDLE: begin
            s_ready = 1'b1;
            if (s_valid) begin
               row_d = '0;
               if (hdr_ok) begin
                  col_d   = hdr_col;
                  frm_d   = hdr_frm;
                  state_d = LOAD;
               end else begin
                  err_d   = 1'b1;
                  state_d = DISCARD;
               end
            end
         end
         LOAD: begin
            s_ready = 1'b1;
            if (s_valid) begin
               wr_en = 1'b1;
               if (row_q == LAST_ROW) begin
                  cnt_d   = '0;
                  state_d = STROBE;
               end else begin
                  row_d = row_q + 1'b1;
               end
            end
         end
         DISCARD: begin
            s_ready = 1'b1;
            if (s_valid) begin
               if (row_q == LAST_ROW) begin
                  state_d = IDLE;
               end else begin
                  row_d = row_q + 1'b1;
               end
            end
         end
         STROBE: begin
            if (cnt_q == LAST_STB) begin
               state_d = HOLD;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         HOLD: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Control registers; reset discards any frame in flight.
   always_ff @(posedge CLK) begin
      if (!resetn) begin
         state_q <= IDLE;
         row_q   <= '0;
         cnt_q   <= '0;
         col_q   <= '0;
         frm_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         row_q   <= row_d;
         cnt_q   <= cnt_d;
         col_q   <= col_d;
         frm_q   <= frm_d;
         err_q   <= err_d;
      end
   end

   // FrameData row storage, written only by accepted LOAD words.
   always_ff @(posedge CLK) begin
      if (!resetn) begin
         frame_data_q <= '0;
      end else if (wr_en) begin
         frame_data_q[int'(row_q) * FrameBitsPerRow +: FrameBitsPerRow] <= s_data;
      end
   end

   // Enable is taken from the next state so the registered strobe lines up
   // exactly with the STROBE cycles.
   frame_strobe_decoder #(
      .NumColumns      (NumColumns),
      .MaxFramesPerCol (MaxFramesPerCol)
   ) u_strobe_dec (
      .clk_i    (CLK),
      .rst_ni   (resetn),
      .en_i     (state_d == STROBE),
      .col_i    (col_q),
      .frame_i  (frm_q),
      .strobe_o (FrameStrobe)
   );

   assign FrameData  = frame_data_q;
   assign frame_done = (state_q == HOLD);
   assign frame_err  = err_q;
   assign busy       = (state_q != IDLE);
   assign dbg_state  = state_q;

endmodule

// File: tb/tb_config_frame_writer.sv
// Bench for config_frame_writer: per-cycle vector table for single-strobe
// frames, plus hand-written sequences for gapped loading and mid-strobe reset.
module tb_config_frame_writer;
   import config_frame_pkg::*;

   localparam int NR = 8;
   localparam int FB = 32;
   localparam int NC = 10;
   localparam int MF = 20;

   // Clock / reset
   logic CLK = 1'b0;
   logic resetn;
   always #5 CLK = ~CLK;

   // DUT with one-cycle strobe
   logic              s_valid;
   logic              s_ready;
   logic [FB-1:0]     s_data;
   logic [NR*FB-1:0]  FrameData;
   logic [NC*MF-1:0]  FrameStrobe;
   logic              frame_done, frame_err, busy;
   state_e            dbg_state;

   // DUT with three-cycle strobe
   logic              s_valid3;
   logic              s_ready3;
   logic [FB-1:0]     s_data3;
   logic [NR*FB-1:0]  FrameData3;
   logic [NC*MF-1:0]  FrameStrobe3;
   logic              frame_done3, frame_err3, busy3;
   state_e            dbg_state3;

   config_frame_writer #(
      .MaxFramesPerCol (MF), .FrameBitsPerRow (FB), .NumRows (NR),
      .NumColumns (NC), .StrobeCycles (1)
   ) dut (
      .CLK (CLK), .resetn (resetn), .s_valid (s_valid), .s_ready (s_ready),
      .s_data (s_data), .FrameData (FrameData), .FrameStrobe (FrameStrobe),
      .frame_done (frame_done), .frame_err (frame_err), .busy (busy),
      .dbg_state (dbg_state)
   );

   config_frame_writer #(
      .MaxFramesPerCol (MF), .FrameBitsPerRow (FB), .NumRows (NR),
      .NumColumns (NC), .StrobeCycles (3)
   ) dut3 (
      .CLK (CLK), .resetn (resetn), .s_valid (s_valid3), .s_ready (s_ready3),
      .s_data (s_data3), .FrameData (FrameData3), .FrameStrobe (FrameStrobe3),
      .frame_done (frame_done3), .frame_err (frame_err3), .busy (busy3),
      .dbg_state (dbg_state3)
   );

   // One cycle of stimulus and the outputs expected during that cycle.
   typedef struct {
      logic          v;
      logic [FB-1:0] d;
      logic          rdy;
      logic          bsy;
      logic          done;
      logic          err;
      int            sidx;    // expected strobe bit, -1 for all-zero
      int            wr_row;  // row this word writes, -1 for none
   } vec_t;

   vec_t             vecs[$];
   logic [NR*FB-1:0] exp_fd;
   logic [NR*FB-1:0] exp_fd3;
   int               n_checks = 0;
   int               n_errors = 0;

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [FB-1:0] hdr(input int col, input int frm);
      // Upper bits are junk on purpose; the decoder must ignore them.
      return {16'hFFFF, 8'(frm), 8'(col)};
   endfunction

   task automatic push(input logic v, input logic [FB-1:0] d, input logic rdy,
                       input logic bsy, input logic done, input logic err,
                       input int sidx, input int wr_row);
      vec_t e;
      e.v = v; e.d = d; e.rdy = rdy; e.bsy = bsy; e.done = done; e.err = err;
      e.sidx = sidx; e.wr_row = wr_row;
      vecs.push_back(e);
   endtask

   // Header, NumRows words, one STROBE cycle, one HOLD cycle.
   task automatic fill_frame(input int col, input int frm, input logic [FB-1:0] base);
      push(1'b1, hdr(col, frm), 1'b1, 1'b0, 1'b0, 1'b0, -1, -1);
      for (int r = 0; r < NR; r++)
         push(1'b1, base + FB'(r), 1'b1, 1'b1, 1'b0, 1'b0, -1, r);
      push(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, col * MF + frm, -1);
      push(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, -1, -1);
   endtask

   // Rejected header followed by NumRows discarded words.
   task automatic fill_err(input int col, input int frm, input logic [FB-1:0] base);
      push(1'b1, hdr(col, frm), 1'b1, 1'b0, 1'b0, 1'b0, -1, -1);
      for (int r = 0; r < NR; r++)
         push(1'b1, base + FB'(r), 1'b1, 1'b1, 1'b0, (r == 0), -1, -1);
   endtask

   task automatic fill_idle();
      push(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, -1, -1);
   endtask

   // Apply the first n table entries on dut, checking every output each cycle.
   task automatic run_vecs(input int n);
      logic [NC*MF-1:0] exp_stb;
      for (int i = 0; i < n; i++) begin
         @(negedge CLK);
         s_valid = vecs[i].v;
         s_data  = vecs[i].d;
         exp_stb = '0;
         if (vecs[i].sidx >= 0) exp_stb[vecs[i].sidx] = 1'b1;
         chk($sformatf("v%0d.s_ready", i),     s_ready,     vecs[i].rdy);
         chk($sformatf("v%0d.busy", i),        busy,        vecs[i].bsy);
         chk($sformatf("v%0d.frame_done", i),  frame_done,  vecs[i].done);
         chk($sformatf("v%0d.frame_err", i),   frame_err,   vecs[i].err);
         chk($sformatf("v%0d.FrameStrobe", i), FrameStrobe, exp_stb);
         chk($sformatf("v%0d.FrameData", i),   FrameData,   exp_fd);
         if (vecs[i].wr_row >= 0) exp_fd[vecs[i].wr_row * FB +: FB] = vecs[i].d;
      end
      vecs.delete();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int rows;
      int cyc;
      logic v;

      resetn = 1'b0;
      s_valid = 1'b0; s_data = '0;
      s_valid3 = 1'b0; s_data3 = '0;
      exp_fd = '0; exp_fd3 = '0;
      repeat (3) @(negedge CLK);
      chk("rst.FrameData",   FrameData,   '0);
      chk("rst.FrameStrobe", FrameStrobe, '0);
      chk("rst.busy",        busy,        1'b0);
      chk("rst.frame_done",  frame_done,  1'b0);
      chk("rst.frame_err",   frame_err,   1'b0);
      chk("rst.busy3",       busy3,       1'b0);
      resetn = 1'b1;

      // Frame col 3 / frame 5, then a bad column, then a bad frame index.
      fill_frame(3, 5, 32'hA000_0000);
      fill_idle();
      fill_err(10, 0, 32'hDEAD_0000);
      fill_idle();
      fill_err(2, 20, 32'hBEEF_0000);
      fill_idle();
      run_vecs(vecs.size());
      for (int r = 0; r < NR; r++)
         chk($sformatf("t1.row%0d", r), FrameData[r*FB +: FB], 32'hA000_0000 + r);

      // Three-cycle strobe with random s_valid gaps during LOAD.
      @(negedge CLK);
      chk("t3.idle_ready", s_ready3, 1'b1);
      s_valid3 = 1'b1; s_data3 = hdr(0, 0);
      rows = 0; cyc = 0;
      while (rows < NR && cyc < 200) begin
         @(negedge CLK);
         chk("t3.load_ready",  s_ready3,     1'b1);
         chk("t3.load_strobe", FrameStrobe3, '0);
         chk("t3.load_data",   FrameData3,   exp_fd3);
         v = 1'($urandom_range(0, 1));
         s_valid3 = v;
         s_data3  = v ? 32'h5000_0000 + 32'(rows * 32'h111) : $urandom();
         if (v) begin
            exp_fd3[rows*FB +: FB] = s_data3;
            rows++;
         end
         cyc++;
      end
      if (rows < NR) chk("t3.load_timeout", rows, NR);
      for (int k = 0; k < 3; k++) begin
         @(negedge CLK);
         s_valid3 = 1'b0;
         chk($sformatf("t3.strobe%0d", k), FrameStrobe3, 1);
         chk($sformatf("t3.data%0d", k),   FrameData3,   exp_fd3);
         chk($sformatf("t3.ready%0d", k),  s_ready3,     1'b0);
         chk($sformatf("t3.done%0d", k),   frame_done3,  1'b0);
      end
      @(negedge CLK);
      chk("t3.hold_strobe", FrameStrobe3, '0);
      chk("t3.hold_done",   frame_done3,  1'b1);
      chk("t3.hold_data",   FrameData3,   exp_fd3);
      chk("t3.hold_ready",  s_ready3,     1'b0);
      @(negedge CLK);
      chk("t3.idle_busy",   busy3,        1'b0);
      chk("t3.idle_ready2", s_ready3,     1'b1);

      // Reset asserted during STROBE, then a clean frame.
      fill_frame(1, 2, 32'hC000_0000);
      run_vecs(NR + 2);
      resetn = 1'b0;
      @(negedge CLK);
      chk("t4.FrameStrobe", FrameStrobe, '0);
      chk("t4.FrameData",   FrameData,   '0);
      chk("t4.busy",        busy,        1'b0);
      chk("t4.frame_done",  frame_done,  1'b0);
      resetn = 1'b1;
      exp_fd = '0;
      fill_frame(4, 7, 32'hD000_0000);
      fill_idle();
      run_vecs(vecs.size());

      // Back-to-back frames: second header in the first IDLE cycle after HOLD.
      fill_frame(9, 19, 32'hB000_0000);
      fill_frame(0, 1, 32'hE000_0000);
      fill_idle();
      run_vecs(vecs.size());
      for (int r = 0; r < NR; r++)
         chk($sformatf("t5.row%0d", r), FrameData[r*FB +: FB], 32'hE000_0000 + r);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
